// File: rtl/switch_debounce_fifo.sv
// switch_debounce_fifo: synchronise and debounce four active-low switches and queue each state change as a byte
module switch_debounce_fifo #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    sw_n,
    output logic [3:0]                    sw_state,
    output logic                          change_pulse,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic          pulse_q, pulse_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    differ, term;
    logic          push, pop, accept;

    // Terminal count is DEBOUNCE_CYCLES-2 so the flip lands on the edge the counter would reach DEBOUNCE_CYCLES-1
    always_comb begin
        sync1_d = sw_n;
        sync2_d = sync1_q;
        differ  = ~sync2_q ^ state_q;
        for (int i = 0; i < 4; i++) begin
            term[i]  = differ[i] && (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 2));
            cnt_d[i] = (!differ[i] || term[i]) ? '0 : cnt_q[i] + 1'b1;
        end
        state_d = state_q ^ term;
        pulse_d = |term;
    end

    // FIFO bookkeeping: a full FIFO still accepts when the head leaves at the same edge
    always_comb begin
        push    = state_d != state_q;
        pop     = (count_q != '0) && out_ready;
        accept  = push && ((count_q != (PW+1)'(FIFO_DEPTH)) || pop);
        mem_d   = mem_q;
        if (accept) mem_d[wr_q] = state_d;
        wr_d    = wr_q + PW'(accept);
        rd_d    = rd_q + PW'(pop);
        count_d = count_q + (PW+1)'(accept) - (PW+1)'(pop);
        ovf_d   = ovf_q | (push & ~accept);
    end

    // State registers; synchroniser resets to released so reset never produces an event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            state_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            pulse_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sw_state     = state_q;
    assign change_pulse = pulse_q;
    assign out_valid    = count_q != '0;
    assign out_data     = out_valid ? {4'b0000, mem_q[rd_q]} : 8'h00;
    assign fifo_count   = count_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_switch_debounce_fifo.sv
// tb_switch_debounce_fifo: directed and random checks against a window-based debounce and queue model
module tb_switch_debounce_fifo;
    localparam int DC = 8;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_n = 4'hF;
    logic       out_ready = 1'b0;
    logic [3:0] sw_state;
    logic       change_pulse;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] fifo_count;
    logic       overflow;

    switch_debounce_fifo #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .sw_n(sw_n), .sw_state(sw_state),
        .change_pulse(change_pulse), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int events = 0;
    logic [3:0] hist[$];
    logic [7:0] mq[$];
    logic [3:0] m_state;
    logic       m_pulse, m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Raw samples before reset release count as released switches
    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < DC; i++) hist.push_back(4'hF);
        mq.delete();
        m_state = 4'h0;
        m_pulse = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    // A bit flips once the synchronised input has disagreed for DC-1 consecutive samples (2-edge sync delay)
    function automatic void model_edge();
        logic [3:0] ns;
        bit pop;
        hist.push_back(sw_n);
        if (hist.size() > DC + 1) void'(hist.pop_front());
        ns = m_state;
        for (int b = 0; b < 4; b++) begin
            bit all = 1'b1;
            for (int i = 0; i <= DC - 2; i++)
                if ((~hist[i][b]) == m_state[b]) all = 1'b0;
            if (all) ns[b] = ~m_state[b];
        end
        pop = (mq.size() != 0) && out_ready;
        if (pop) void'(mq.pop_front());
        m_pulse = ns != m_state;
        if (m_pulse) begin
            events++;
            if (mq.size() < FD) mq.push_back({4'b0000, ns});
            else m_ovf = 1'b1;
        end
        m_state = ns;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("sw_state", sw_state, m_state);
        chk("change_pulse", change_pulse, m_pulse);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_data", out_data, mq.size() != 0 ? mq[0] : 8'h00);
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #3;
        chk("rst_sw_state", sw_state, 4'h0);
        chk("rst_pulse", change_pulse, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] fill_sw [5];
        logic [7:0] fill_exp [4];
        int npulse;
        int hold;
        fill_sw[0] = 4'b0111; fill_sw[1] = 4'b0011; fill_sw[2] = 4'b0001;
        fill_sw[3] = 4'b0000; fill_sw[4] = 4'b1000;
        fill_exp[0] = 8'h08; fill_exp[1] = 8'h0C; fill_exp[2] = 8'h0E; fill_exp[3] = 8'h0F;

        do_reset();
        out_ready = 1'b1;
        npulse = 0;
        repeat (100) begin
            step();
            npulse += int'(change_pulse);
        end
        chk("idle_no_pulse", npulse, 0);

        sw_n = 4'b0111;
        repeat (8) step();
        chk("press_early", sw_state, 4'h0);
        step();
        chk("press_state", sw_state, 4'h8);
        chk("press_pulse", change_pulse, 1'b1);
        chk("press_data", out_data, 8'h08);
        step();
        chk("press_drained", out_valid, 1'b0);
        sw_n = 4'hF;
        repeat (12) step();

        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            sw_n[0] = ~sw_n[0];
            repeat (5) begin
                step();
                npulse += int'(change_pulse);
            end
        end
        chk("bounce_quiet", npulse, 0);
        sw_n[0] = 1'b0;
        repeat (9) step();
        chk("bounce_state", sw_state, 4'h1);
        chk("bounce_data", out_data, 8'h01);
        sw_n = 4'hF;
        repeat (12) step();

        out_ready = 1'b0;
        sw_n = 4'b1001;
        repeat (9) step();
        chk("simul_count", fifo_count, 3'd1);
        chk("simul_data", out_data, 8'h06);
        out_ready = 1'b1;
        sw_n = 4'hF;
        repeat (12) step();

        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sw_n = fill_sw[k];
            repeat (12) step();
        end
        chk("fill_count", fifo_count, 3'd4);
        chk("fill_overflow", overflow, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", out_data, fill_exp[k]);
            step();
        end
        chk("drain_empty", out_valid, 1'b0);

        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sw_n = fill_sw[k];
            repeat (12) step();
        end
        sw_n = 4'b0111;
        repeat (8) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pp_count", fifo_count, 3'd4);
        chk("pp_overflow", overflow, 1'b0);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("pp_order", out_data, fill_exp[k]);
            step();
        end
        chk("pp_last", out_data, 8'h08);
        step();

        do_reset();
        events = 0;
        hold = 0;
        repeat (3000) begin
            if (hold == 0) begin
                sw_n = ($urandom_range(0, 1) == 0) ? sw_n ^ 4'($urandom) : sw_n;
                hold = $urandom_range(1, 14);
            end
            hold--;
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        chk("random_events", events >= 10, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
